// File: rtl/secuenciador_instrucciones.sv
// Instruction issue unit: loadable program memory, sequential fetch from address 0,
// valid/ready issue to the datapath, ending at a programmed length or a HALT word.
module secuenciador_instrucciones #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [17:0]   prog_data,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    output logic [17:0]   instruccion,
    output logic          valid,
    input  logic          ready,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc,
    output logic [AW:0]   issued_count
);

    localparam int unsigned IW = 18;
    localparam logic [IW-1:0] HALT = 18'h3FFFF;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, FIN} state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] mem [DEPTH];
    logic [AW:0]   len_q;
    logic [AW:0]   len_eff;
    logic [AW:0]   count_inc;
    logic          is_halt;
    logic          accept;

    // Requested length clamped to the memory size.
    assign len_eff   = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
    assign count_inc = issued_count + (AW+1)'(1);
    assign is_halt   = (instruccion == HALT);
    assign accept    = (state == ISSUE) && !is_halt && ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len_eff == '0) ? FIN : FETCH;
                end
            end
            FETCH: state_next = ISSUE;
            ISSUE: begin
                if (is_halt) begin
                    state_next = FIN;
                end else if (ready) begin
                    state_next = (count_inc == len_q) ? FIN : FETCH;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs; a HALT word is held back from the datapath.
    always_comb begin
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE:    busy = 1'b0;
            FETCH:   busy = 1'b1;
            ISSUE: begin
                busy  = 1'b1;
                valid = !is_halt;
            end
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Program counter, issue counter, latched length and fetched word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            issued_count <= '0;
            len_q        <= '0;
            instruccion  <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                pc           <= '0;
                issued_count <= '0;
                len_q        <= len_eff;
            end
            if (state == FETCH) begin
                instruccion <= mem[pc];
            end
            if (accept) begin
                pc           <= pc + AW'(1);
                issued_count <= count_inc;
            end
        end
    end

    // Program memory is writable only while idle and is not cleared by reset.
    always_ff @(posedge clk) begin
        if (prog_we && (state == IDLE)) begin
            mem[prog_addr] <= prog_data;
        end
    end

endmodule
